regfile_debug_port: RTL and testbench

Debug access sequencer for the 16×16-bit CPU register file. On command, it either loads all registers from an 8-bit byte stream (LOAD) or reads them all out to an 8-bit byte stream (DUMP). It drives the register file's write and read ports while holding the CPU. It sits between the debug link and the register file, and is the initiator that sequences the file's read/write ports.

---
 rtl/regfile_debug_port_pkg.sv | 25 ++
 rtl/regfile_debug_port_if.sv | 34 +++
 rtl/regfile_debug_port.sv | 101 ++++++++++
 tb/tb_regfile_debug_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_debug_port_pkg.sv
// rtl/regfile_debug_port_pkg.sv - shared constants and state encoding for the register file debug port
package regfile_dbg_pkg;

    localparam int NUM_REGS   = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_DUMP = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_HI,
        ST_LD_LO,
        ST_LD_WR,
        ST_DP_RD,
        ST_DP_HI,
        ST_DP_LO,
        ST_DONE
    } state_t;

endpackage

// File: rtl/regfile_debug_port_if.sv
// rtl/regfile_debug_port_if.sv - command, byte stream and register file port bundle
interface regfile_debug_port_if;
    import regfile_dbg_pkg::*;

    logic                  Start;
    logic                  Mode;
    logic [BYTE_WIDTH-1:0] InData;
    logic                  InValid;
    logic                  InReady;
    logic [BYTE_WIDTH-1:0] OutData;
    logic                  OutValid;
    logic                  OutReady;
    logic [ADDR_WIDTH-1:0] DbgWriteRegister;
    logic [DATA_WIDTH-1:0] DbgWriteData;
    logic                  DbgRegWrite;
    logic [ADDR_WIDTH-1:0] DbgReadRegister;
    logic [DATA_WIDTH-1:0] DbgReadData;
    logic                  Busy;
    logic                  Done;

    // The sequencer is the initiator towards the register file.
    modport master (
        input  Start, Mode, InData, InValid, OutReady, DbgReadData,
        output InReady, OutData, OutValid, DbgWriteRegister, DbgWriteData,
               DbgRegWrite, DbgReadRegister, Busy, Done
    );

    modport slave (
        output Start, Mode, InData, InValid, OutReady, DbgReadData,
        input  InReady, OutData, OutValid, DbgWriteRegister, DbgWriteData,
               DbgRegWrite, DbgReadRegister, Busy, Done
    );

endinterface

// File: rtl/regfile_debug_port.sv
// rtl/regfile_debug_port.sv - LOAD/DUMP sequencer between a byte-wide debug link and the register file
module regfile_debug_port
    import regfile_dbg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_debug_port_if.master bus
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [BYTE_WIDTH-1:0] hi;
    logic [BYTE_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] held;
    logic                  is_last;

    assign is_last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are decoded from state alone so an async reset drops them at once.
    always_comb begin
        state_nxt            = state;
        bus.InReady          = 1'b0;
        bus.OutValid         = 1'b0;
        bus.OutData          = '0;
        bus.DbgRegWrite      = 1'b0;
        bus.DbgWriteRegister = '0;
        bus.DbgWriteData     = '0;
        bus.DbgReadRegister  = '0;
        bus.Done             = 1'b0;
        bus.Busy             = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_nxt = (bus.Mode == MODE_DUMP) ? ST_DP_RD : ST_LD_HI;
                end
            end
            ST_LD_HI: begin
                bus.InReady = 1'b1;
                if (bus.InValid) state_nxt = ST_LD_LO;
            end
            ST_LD_LO: begin
                bus.InReady = 1'b1;
                if (bus.InValid) state_nxt = ST_LD_WR;
            end
            ST_LD_WR: begin
                bus.DbgRegWrite      = 1'b1;
                bus.DbgWriteRegister = idx;
                bus.DbgWriteData     = {hi, lo};
                state_nxt            = is_last ? ST_DONE : ST_LD_HI;
            end
            ST_DP_RD: begin
                bus.DbgReadRegister = idx;
                state_nxt           = ST_DP_HI;
            end
            ST_DP_HI: begin
                bus.OutValid = 1'b1;
                bus.OutData  = held[DATA_WIDTH-1 -: BYTE_WIDTH];
                if (bus.OutReady) state_nxt = ST_DP_LO;
            end
            ST_DP_LO: begin
                bus.OutValid = 1'b1;
                bus.OutData  = held[BYTE_WIDTH-1:0];
                if (bus.OutReady) state_nxt = is_last ? ST_DONE : ST_DP_RD;
            end
            ST_DONE: begin
                bus.Done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            hi   <= '0;
            lo   <= '0;
            held <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (bus.Start) idx <= '0;
                ST_LD_HI: if (bus.InValid) hi <= bus.InData;
                ST_LD_LO: if (bus.InValid) lo <= bus.InData;
                ST_LD_WR: if (!is_last) idx <= idx + 1'b1;
                ST_DP_RD: held <= bus.DbgReadData;
                ST_DP_LO: if (bus.OutReady && !is_last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_debug_port.sv
// tb/tb_regfile_debug_port.sv - directed bench for the register file debug port
module tb_regfile_debug_port;
    import regfile_dbg_pkg::*;

    logic clk;
    logic rst_n;

    regfile_debug_port_if bus();

    regfile_debug_port dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int N     = 0;

    // Register file model behind the debug ports.
    logic [15:0] regs [16];
    logic        preload_req = 1'b0;
    logic [15:0] preload_base = '0;

    assign bus.DbgReadData = regs[bus.DbgReadRegister];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload_req) begin
            for (int k = 0; k < 16; k++) regs[k] <= preload_base + 16'(k);
        end else if (bus.DbgRegWrite) begin
            regs[bus.DbgWriteRegister] <= bus.DbgWriteData;
        end
    end

    logic [3:0]  wr_idx_q [$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q [$];
    logic [7:0]  out_q    [$];
    int          out_cyc_q[$];
    int          done_cnt  = 0;
    int          done_edge = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = '0;

    logic [7:0]  in_bytes [32];
    logic [15:0] vals     [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: cyc here is the index of the upcoming rising edge.
    always @(negedge clk) begin
        if (bus.DbgRegWrite) begin
            wr_idx_q.push_back(bus.DbgWriteRegister);
            wr_data_q.push_back(bus.DbgWriteData);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.OutValid && bus.OutReady) begin
            out_q.push_back(bus.OutData);
            out_cyc_q.push_back(cyc);
        end
        if (stall_prev && bus.OutValid) chk("stall_hold", bus.OutData, stall_data);
        stall_prev = bus.OutValid && !bus.OutReady;
        stall_data = bus.OutData;
        if (bus.Done) begin
            done_cnt++;
            done_edge = cyc;
        end
    end

    task automatic clear_logs();
        wr_idx_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        out_q.delete(); out_cyc_q.delete();
    endtask

    task automatic build_bytes();
        for (int k = 0; k < 16; k++) begin
            in_bytes[2*k]   = vals[k][15:8];
            in_bytes[2*k+1] = vals[k][7:0];
        end
    endtask

    task automatic preload(input logic [15:0] base);
        preload_base = base;
        preload_req  = 1'b1;
        @(posedge clk); #1;
        preload_req  = 1'b0;
    endtask

    task automatic start_cmd(input logic m);
        bus.Start = 1'b1;
        bus.Mode  = m;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        N = cyc - 1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.Busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_reached", bus.Busy, 0);
    endtask

    task automatic drive_load(input int limit, input bit gappy);
        int   bi = 0;
        int   t  = 0;
        logic acc;
        start_cmd(MODE_LOAD);
        while (bi < limit && t < 500) begin
            bus.InValid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.InData  = in_bytes[bi];
            acc = bus.InValid && bus.InReady;
            @(posedge clk); #1;
            t++;
            if (acc) bi++;
        end
        bus.InValid = 1'b0;
        chk("ld_feed", bi, limit);
    endtask

    task automatic drive_dump(input bit toggle, input bit poke);
        int t  = 0;
        int d0 = done_cnt;
        start_cmd(MODE_DUMP);
        while (done_cnt == d0 && t < 500) begin
            if (toggle) bus.OutReady = ~bus.OutReady;
            bus.Start = poke && (t == 10);
            bus.Mode  = MODE_LOAD;
            @(posedge clk); #1;
            t++;
        end
        bus.Start    = 1'b0;
        bus.OutReady = 1'b1;
        wait_idle();
    endtask

    int d0;

    initial begin
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.Mode     = 1'b0;
        bus.InData   = '0;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        preload(16'h0000);
        @(posedge clk); #1;
        chk("rst_busy",   bus.Busy, 0);
        chk("rst_done",   bus.Done, 0);
        chk("rst_inrdy",  bus.InReady, 0);
        chk("rst_outvld", bus.OutValid, 0);
        chk("rst_outdat", bus.OutData, 0);
        chk("rst_wr",     bus.DbgRegWrite, 0);
        chk("rst_rdidx",  bus.DbgReadRegister, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LOAD, continuous: R k = 0x0010 + k
        for (int k = 0; k < 16; k++) vals[k] = 16'h0010 + 16'(k);
        build_bytes();
        clear_logs();
        d0 = done_cnt;
        drive_load(32, 1'b0);
        wait_idle();
        chk("ld_nwr", wr_idx_q.size(), 16);
        for (int k = 0; k < 16 && k < wr_idx_q.size(); k++) begin
            chk($sformatf("ld_idx%0d", k),  wr_idx_q[k], k);
            chk($sformatf("ld_dat%0d", k),  wr_data_q[k], 16'h0010 + 16'(k));
            chk($sformatf("ld_edge%0d", k), wr_cyc_q[k], N + 3 + 3*k);
        end
        chk("ld_done_n",    done_cnt - d0, 1);
        chk("ld_done_edge", done_edge, N + 49);
        chk("ld_r5",        regs[5], 16'h0015);

        // DUMP, continuous: R k = 0xA000 + k
        preload(16'hA000);
        clear_logs();
        d0 = done_cnt;
        drive_dump(1'b0, 1'b0);
        chk("dp_nbytes", out_q.size(), 32);
        for (int i = 0; i < 32 && i < out_q.size(); i++)
            chk($sformatf("dp_b%0d", i), out_q[i], (i % 2 == 0) ? 8'hA0 : 8'(i / 2));
        for (int k = 0; k < 16 && 2*k < out_cyc_q.size(); k++)
            chk($sformatf("dp_edge%0d", k), out_cyc_q[2*k], N + 2 + 3*k);
        chk("dp_done_n",    done_cnt - d0, 1);
        chk("dp_done_edge", done_edge, N + 49);
        chk("dp_nowr",      wr_idx_q.size(), 0);

        // DUMP with OutReady toggling and a Start pulse mid-command
        clear_logs();
        d0 = done_cnt;
        drive_dump(1'b1, 1'b1);
        chk("bp_nbytes", out_q.size(), 32);
        for (int i = 0; i < 32 && i < out_q.size(); i++)
            chk($sformatf("bp_b%0d", i), out_q[i], (i % 2 == 0) ? 8'hA0 : 8'(i / 2));
        chk("bp_done_n", done_cnt - d0, 1);
        chk("bp_nowr",   wr_idx_q.size(), 0);

        // LOAD with random InValid gaps: R k = 0x5A00 + k
        for (int k = 0; k < 16; k++) vals[k] = 16'h5A00 + 16'(k);
        build_bytes();
        clear_logs();
        d0 = done_cnt;
        drive_load(32, 1'b1);
        wait_idle();
        chk("gl_nwr", wr_idx_q.size(), 16);
        for (int k = 0; k < 16 && k < wr_idx_q.size(); k++) begin
            chk($sformatf("gl_idx%0d", k), wr_idx_q[k], k);
            chk($sformatf("gl_dat%0d", k), wr_data_q[k], 16'h5A00 + 16'(k));
        end
        chk("gl_done_n", done_cnt - d0, 1);
        chk("gl_r15",    regs[15], 16'h5A0F);

        // Reset during LD_LO of R7
        for (int k = 0; k < 16; k++) vals[k] = 16'h3100 + 16'(k);
        build_bytes();
        clear_logs();
        d0 = done_cnt;
        drive_load(15, 1'b0);
        chk("ra_inrdy_pre", bus.InReady, 1);
        rst_n = 1'b0;
        #1;
        chk("ra_busy",  bus.Busy, 0);
        chk("ra_inrdy", bus.InReady, 0);
        chk("ra_wr",    bus.DbgRegWrite, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("ra_nwr",    wr_idx_q.size(), 7);
        chk("ra_done_n", done_cnt - d0, 0);
        chk("ra_busy2",  bus.Busy, 0);
        for (int k = 0; k < 7; k++) chk($sformatf("ra_r%0d", k), regs[k], 16'h3100 + 16'(k));
        chk("ra_r7", regs[7], 16'h5A07);

        // InValid in IDLE is not consumed
        clear_logs();
        bus.InValid = 1'b1;
        bus.InData  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("idle_inrdy%0d", i), bus.InReady, 0);
        end
        bus.InValid = 1'b0;
        chk("idle_busy", bus.Busy, 0);
        chk("idle_nwr",  wr_idx_q.size(), 0);

        // Round trip LOAD then DUMP
        vals = '{16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE, 16'h1234, 16'hABCD, 16'h00FF, 16'hFF00,
                 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468, 16'hDEAD, 16'hBEEF};
        build_bytes();
        clear_logs();
        drive_load(32, 1'b0);
        wait_idle();
        clear_logs();
        drive_dump(1'b0, 1'b0);
        chk("rt_nbytes", out_q.size(), 32);
        for (int i = 0; i < 32 && i < out_q.size(); i++)
            chk($sformatf("rt_b%0d", i), out_q[i], in_bytes[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
